// File: rtl/alu_uart_intf.sv
// Board-side ALU responder: gathers an A/B/opcode frame from the UART receiver,
// runs the 8-bit ALU operation and hands the result byte to the UART transmitter.
module alu_uart_intf #(
    parameter int Bits          = 8,
    parameter int TIMEOUT_TICKS = 1_000_000
) (
    input  logic            i_Clock,
    input  logic            i_reset,
    input  logic            rx_to_intf_done,
    input  logic [Bits-1:0] rx_to_intf_data,
    input  logic            tx_to_intf_done,
    input  logic            tx_to_intf_active,
    output logic            tx_start,
    output logic [Bits-1:0] intf_to_tx_result,
    output logic            o_busy,
    output logic            o_op_error,
    output logic [2:0]      o_state
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    localparam int              CntW      = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
    localparam logic [CntW-1:0] CntLast   = CntW'((TIMEOUT_TICKS > 0) ? TIMEOUT_TICKS - 1 : 0);
    localparam bit              TimeoutEn = (TIMEOUT_TICKS > 0);

    localparam logic [Bits-1:0] OpAdd = Bits'(8'h20);
    localparam logic [Bits-1:0] OpSub = Bits'(8'h22);
    localparam logic [Bits-1:0] OpAnd = Bits'(8'h24);
    localparam logic [Bits-1:0] OpOr  = Bits'(8'h25);
    localparam logic [Bits-1:0] OpXor = Bits'(8'h26);
    localparam logic [Bits-1:0] OpNor = Bits'(8'h27);
    localparam logic [Bits-1:0] OpSra = Bits'(8'h03);
    localparam logic [Bits-1:0] OpSrl = Bits'(8'h02);

    state_t          state_q, state_d;
    logic [Bits-1:0] a_q, a_d;
    logic [Bits-1:0] b_q, b_d;
    logic [Bits-1:0] op_q, op_d;
    logic [Bits-1:0] result_q, result_d;
    logic            tx_start_q, tx_start_d;
    logic            busy_q, busy_d;
    logic            op_error_q, op_error_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [Bits-1:0] alu_res;
    logic            alu_err;
    logic            expired;

    // Shift amounts of Bits or more fall out naturally as all-sign or all-zero.
    always_comb begin
        alu_res = '1;
        alu_err = 1'b0;
        case (op_q)
            OpAdd:   alu_res = a_q + b_q;
            OpSub:   alu_res = a_q - b_q;
            OpAnd:   alu_res = a_q & b_q;
            OpOr:    alu_res = a_q | b_q;
            OpXor:   alu_res = a_q ^ b_q;
            OpNor:   alu_res = ~(a_q | b_q);
            OpSra:   alu_res = $unsigned($signed(a_q) >>> b_q);
            OpSrl:   alu_res = a_q >> b_q;
            default: begin
                alu_res = '1;
                alu_err = 1'b1;
            end
        endcase
    end

    assign expired = TimeoutEn && (cnt_q == CntLast);

    // A byte arriving on the expiry cycle takes priority over the resync.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        result_d   = result_q;
        op_error_d = op_error_q;
        tx_start_d = 1'b0;
        cnt_d      = cnt_q;
        case (state_q)
            WAIT_A: begin
                cnt_d = '0;
                if (rx_to_intf_done) begin
                    a_d        = rx_to_intf_data;
                    op_error_d = 1'b0;
                    state_d    = WAIT_B;
                end
            end
            WAIT_B, WAIT_OP: begin
                if (rx_to_intf_done) begin
                    if (state_q == WAIT_B) begin
                        b_d     = rx_to_intf_data;
                        state_d = WAIT_OP;
                    end else begin
                        op_d    = rx_to_intf_data;
                        state_d = EXEC;
                    end
                    cnt_d = '0;
                end else if (expired) begin
                    state_d = WAIT_A;
                    cnt_d   = '0;
                end else if (TimeoutEn) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            EXEC: begin
                result_d   = alu_res;
                op_error_d = alu_err;
                tx_start_d = !tx_to_intf_active;
                cnt_d      = '0;
                state_d    = SEND;
            end
            SEND: begin
                if (tx_start_q) begin
                    state_d = WAIT_TX;
                end else begin
                    tx_start_d = !tx_to_intf_active;
                end
            end
            WAIT_TX: begin
                if (tx_to_intf_done) begin
                    state_d = WAIT_A;
                end
            end
            default: state_d = WAIT_A;
        endcase
        busy_d = (state_d != WAIT_A);
    end

    always_ff @(posedge i_Clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= WAIT_A;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            result_q   <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            op_error_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            result_q   <= result_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            op_error_q <= op_error_d;
            cnt_q      <= cnt_d;
        end
    end

    assign tx_start          = tx_start_q;
    assign intf_to_tx_result = result_q;
    assign o_busy            = busy_q;
    assign o_op_error        = op_error_q;
    assign o_state           = state_q;

endmodule

// File: tb/tb_alu_uart_intf.sv
// Scoreboard bench for alu_uart_intf: frames are driven from a stimulus process,
// and a monitor compares every tx_start pulse against a queued reference result.
module tb_alu_uart_intf;

    localparam int Bits    = 8;
    localparam int Timeout = 100;

    logic            clk = 1'b0;
    logic            rst;
    logic            rxDone;
    logic [Bits-1:0] rxData;
    logic            txDone;
    logic            txActive;
    logic            txStart;
    logic [Bits-1:0] result;
    logic            busy;
    logic            opError;
    logic [2:0]      state;

    always #5 clk = ~clk;

    alu_uart_intf #(.Bits(Bits), .TIMEOUT_TICKS(Timeout)) dut (
        .i_Clock           (clk),
        .i_reset           (rst),
        .rx_to_intf_done   (rxDone),
        .rx_to_intf_data   (rxData),
        .tx_to_intf_done   (txDone),
        .tx_to_intf_active (txActive),
        .tx_start          (txStart),
        .intf_to_tx_result (result),
        .o_busy            (busy),
        .o_op_error        (opError),
        .o_state           (state)
    );

    typedef struct {
        int res;
        bit err;
    } exp_t;

    exp_t expQ[$];
    exp_t monExp;
    int   checks = 0;
    int   errors = 0;
    logic prevStart = 1'b0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference ALU written in plain integer arithmetic on byte values.
    function automatic int refAlu(input int a, input int b, input int op, output bit err);
        int r;
        int sa;
        err = 1'b0;
        case (op)
            'h20: r = (a + b) % 256;
            'h22: r = (a - b + 256) % 256;
            'h24: r = a & b;
            'h25: r = a | b;
            'h26: r = a ^ b;
            'h27: r = 255 - (a | b);
            'h02: r = (b >= 8) ? 0 : a / (1 << b);
            'h03: begin
                sa = (a >= 128) ? a - 256 : a;
                for (int i = 0; i < b && i < 8; i++)
                    sa = (sa < 0) ? -((1 - sa) / 2) : sa / 2;
                r = (sa + 256) % 256;
            end
            default: begin
                r   = 255;
                err = 1'b1;
            end
        endcase
        return r;
    endfunction

    task automatic pushExpected(input int a, input int b, input int op);
        exp_t e;
        e.res = refAlu(a, b, op, e.err);
        expQ.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input int value);
        rxData = Bits'(value);
        rxDone = 1'b1;
        tick();
        rxDone = 1'b0;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 3)) tick();
    endtask

    // Called in the cycle after the opcode byte was sampled (EXEC).
    task automatic waitStart(input int expLat);
        int n = 1;
        while (!txStart && n < 30) begin
            tick();
            n++;
        end
        if (!txStart) checkOutput("tx_start_wait_expired", 0, 1);
        else checkOutput("start_latency", n, expLat);
        tick();
    endtask

    task automatic finishTx(input bit stray);
        repeat ($urandom_range(0, 4)) tick();
        if (stray) sendByte($urandom_range(0, 255));
        checkOutput("state_wait_tx", int'(state), 5);
        txDone = 1'b1;
        tick();
        txDone = 1'b0;
        checkOutput("state_after_tx_done", int'(state), 0);
        checkOutput("busy_after_tx_done", int'(busy), 0);
    endtask

    task automatic applyStimulus(input int a, input int b, input int op, input bit stray);
        pushExpected(a, b, op);
        sendByte(a);
        gap();
        sendByte(b);
        gap();
        sendByte(op);
        waitStart(2);
        finishTx(stray);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_state"},    int'(state),    0);
        checkOutput({tag, "_busy"},     int'(busy),     0);
        checkOutput({tag, "_tx_start"}, int'(txStart),  0);
        checkOutput({tag, "_result"},   int'(result),   0);
        checkOutput({tag, "_op_error"}, int'(opError),  0);
    endtask

    task automatic pulseReset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        checkReset(tag);
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Monitor: every tx_start pulse must match the oldest outstanding frame.
    always @(negedge clk) begin
        if (!rst) begin
            if (txStart) begin
                checkOutput("start_while_active", int'(txActive), 0);
                checkOutput("start_single_cycle", int'(prevStart), 0);
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_tx_start", 1, 0);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("result", int'(result), monExp.res);
                    checkOutput("op_error", int'(opError), int'(monExp.err));
                end
            end
            prevStart = txStart;
        end else begin
            prevStart = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL global_time_limit: got expired, expected completion");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        int ops[8] = '{'h20, 'h22, 'h24, 'h25, 'h26, 'h27, 'h02, 'h03};
        int a, b, op;

        rst      = 1'b1;
        rxDone   = 1'b0;
        rxData   = '0;
        txDone   = 1'b0;
        txActive = 1'b0;
        repeat (3) tick();
        checkReset("reset");
        rst = 1'b0;
        tick();

        applyStimulus(22, 18, 'h20, 0);
        applyStimulus(18, 22, 'h22, 0);
        applyStimulus('h80, 2, 'h03, 1);
        applyStimulus('h80, 2, 'h02, 0);
        applyStimulus('hF0, 'h3C, 'h27, 1);

        // Unsupported opcode stays flagged until the next frame's first byte.
        applyStimulus(5, 5, 'h99, 0);
        checkOutput("op_error_sticky", int'(opError), 1);
        sendByte(7);
        checkOutput("op_error_cleared", int'(opError), 0);
        checkOutput("state_after_first_byte", int'(state), 1);

        // Partial frame is abandoned exactly Timeout clocks after the last byte.
        repeat (Timeout - 1) tick();
        checkOutput("state_before_expiry", int'(state), 1);
        tick();
        checkOutput("state_after_expiry", int'(state), 0);
        checkOutput("busy_after_expiry", int'(busy), 0);

        // A byte landing on the expiry cycle is still accepted.
        pushExpected(1, 2, 'h20);
        sendByte(1);
        repeat (Timeout - 1) tick();
        sendByte(2);
        checkOutput("byte_on_expiry_accepted", int'(state), 2);
        sendByte('h20);
        waitStart(2);
        finishTx(0);

        // A busy transmitter holds off tx_start until it goes idle.
        pushExpected('h33, 'h44, 'h26);
        sendByte('h33);
        sendByte('h44);
        txActive = 1'b1;
        sendByte('h26);
        repeat (6) tick();
        checkOutput("held_in_send", int'(state), 4);
        checkOutput("no_start_while_active", int'(txStart), 0);
        txActive = 1'b0;
        tick();
        checkOutput("delayed_start", int'(txStart), 1);
        tick();
        finishTx(1);

        // Reset in WAIT_OP discards the frame.
        sendByte(9);
        sendByte(10);
        checkOutput("state_wait_op", int'(state), 2);
        pulseReset("reset_wait_op");
        applyStimulus(1, 2, 'h20, 0);

        // Reset in WAIT_TX.
        pushExpected('hAA, 'h0F, 'h24);
        sendByte('hAA);
        sendByte('h0F);
        sendByte('h24);
        waitStart(2);
        checkOutput("state_in_wait_tx", int'(state), 5);
        pulseReset("reset_wait_tx");
        applyStimulus(1, 2, 'h20, 0);

        for (int i = 0; i < 30; i++) begin
            a  = $urandom_range(0, 255);
            b  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 10) : $urandom_range(0, 255);
            op = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : ops[$urandom_range(0, 7)];
            applyStimulus(a, b, op, 1'($urandom_range(0, 1)));
        end

        repeat (3) tick();
        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_uart_intf.md
# alu_uart_intf

UART-side responder for the ALU link: collects a three-byte command frame (operand A, operand B, opcode) from the UART receiver, executes the 8-bit ALU operation, and hands the one-byte result to the UART transmitter. It sits inside `top` between the `uart` block's receive/transmit handshake signals. Together they form the board-side end of the host-to-board ALU protocol.

## Interface
Parameters:
- `Bits`, 8, data/operand width.
- `TIMEOUT_TICKS`, 1_000_000, max clocks between frame bytes before resync; 0 disables timeout.

Ports:
- `i_Clock`  in  1  system clock.
- `i_reset`  in  1  asynchronous, active-high reset.
- `rx_to_intf_done`  in  1  one-cycle pulse, received byte valid.
- `rx_to_intf_data`  in  Bits  received byte; sampled only when done=1.
- `tx_to_intf_done`  in  1  one-cycle pulse, transmitter finished the stop bit.
- `tx_to_intf_active`  in  1  transmitter busy.
- `tx_start`  out  1  one-cycle pulse requesting transmission.
- `intf_to_tx_result`  out  Bits  byte to transmit.
- `o_busy`  out  1  high in any state other than WAIT_A.
- `o_op_error`  out  1  last opcode was unsupported.
- `o_state`  out  3  current FSM state encoding (debug).

## Operation
- FSM states (encoding): WAIT_A=0, WAIT_B=1, WAIT_OP=2, EXEC=3, SEND=4, WAIT_TX=5.
- WAIT_A: on `rx_to_intf_done`, latch A and go to WAIT_B. Also clear `o_op_error`.
- WAIT_B: on done, latch B and go to WAIT_OP.
- WAIT_OP: on done, latch opcode and go to EXEC.
- EXEC: compute the result, register it into `intf_to_tx_result`, then go to SEND.
- SEND: assert `tx_start` for exactly one cycle.
  - If `tx_to_intf_active` is already high (transmitter busy from a prior frame), stay in SEND with `tx_start`=0 until active is low.
  - After the pulse, go to WAIT_TX.
- WAIT_TX: on `tx_to_intf_done`, go to WAIT_A.
- Opcodes (B used as the shift amount; amounts ≥ Bits saturate naturally):
  - 0x20 ADD: A+B, mod 2^Bits, carry dropped.
  - 0x22 SUB: A−B, two's complement.
  - 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR.
  - 0x03 SRA: arithmetic right shift of signed A by B.
  - 0x02 SRL: logical right shift of A by B.
  - Any other opcode: result 0xFF, `o_op_error`=1 (sticky until the next frame's first byte). The 0xFF result is still transmitted.
- Bytes received in EXEC, SEND or WAIT_TX are dropped. They do not start a new frame.
- Timeout: an inter-byte counter runs in WAIT_B and WAIT_OP and restarts on every accepted byte. When it reaches `TIMEOUT_TICKS`, the FSM returns to WAIT_A and the partial frame is discarded; nothing is transmitted.
  - If done and expiry occur in the same cycle, the byte wins: it is accepted and the counter restarts.
- WAIT_TX has no timeout; it waits for `tx_to_intf_done` indefinitely.

## Timing
- Reset values (asynchronous, immediate): state=WAIT_A, A=B=opcode=0, `intf_to_tx_result`=0, `tx_start`=0, `o_busy`=0, `o_op_error`=0, `o_state`=0, timeout counter=0.
- Reset mid-frame or mid-transmit aborts the frame; no `tx_start` follows.
- Latency: opcode `rx_to_intf_done` at cycle t gives state EXEC at t+1. `tx_start`=1 and the result is valid at cycle t+2 when the transmitter is idle.
- `intf_to_tx_result` holds stable from SEND through WAIT_TX until the next EXEC.
- `tx_start` is never high for more than one consecutive cycle and is never asserted while `tx_to_intf_active`=1.
- All outputs are registered.

## Test plan
- Frame 22, 18, 0x20 → one `tx_start` pulse 2 cycles after the opcode byte, `intf_to_tx_result`=40 (0x28), `o_op_error`=0, FSM back in WAIT_A after `tx_to_intf_done`.
- Frames 18, 22, 0x22 → 0xFC; then 0x80, 2, 0x03 → 0xE0; then 0x80, 2, 0x02 → 0x20; then 0xF0, 0x3C, 0x27 → 0x03.
- Frame 5, 5, 0x99 → result 0xFF transmitted and `o_op_error`=1. The next frame's first byte clears `o_op_error`.
- With `TIMEOUT_TICKS`=100: send A only, wait 100 clocks → FSM returns to WAIT_A with no `tx_start`. Then frame 1, 2, 0x20 → 3.
  - Also: a byte arriving on the exact expiry cycle is accepted.
- Bytes injected during WAIT_TX are ignored; `tx_to_intf_active` held high on entry to SEND delays `tx_start` until it drops.
- Assert `i_reset` in WAIT_OP and in WAIT_TX → all outputs return to reset values immediately. A following full frame (1, 2, 0x20) → result 3.
